// File: rtl/vector_mem_sequencer_if.sv
// vector_mem_sequencer_if: pipeline-side request signals and data-memory port of the vector memory sequencer
interface vector_mem_sequencer_if #(parameter int N = 32, parameter int V = 256);
  logic         en;
  logic         scalar_req;
  logic         vec_req;
  logic         write;
  logic [3:0]   byte_en;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic [V-1:0] wdata_v;
  logic [N-1:0] rdata_mem;
  logic [N-1:0] mem_addr;
  logic [3:0]   mem_byteen;
  logic [N-1:0] mem_wdata;
  logic         mem_rden;
  logic         mem_wren;
  logic [N-1:0] rdata;
  logic [V-1:0] rdata_v;
  logic         busy;
  logic         done_v;
  modport slave (
    input  en, scalar_req, vec_req, write, byte_en, addr, wdata, wdata_v, rdata_mem,
    output mem_addr, mem_byteen, mem_wdata, mem_rden, mem_wren, rdata, rdata_v, busy, done_v
  );
  modport master (
    output en, scalar_req, vec_req, write, byte_en, addr, wdata, wdata_v, rdata_mem,
    input  mem_addr, mem_byteen, mem_wdata, mem_rden, mem_wren, rdata, rdata_v, busy, done_v
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: shares one N-bit data memory port between single-cycle scalar accesses and V/N-beat vector bursts
module vector_mem_sequencer #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vector_mem_sequencer_if.slave  bus
);
  localparam int BEATS = V / N;
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  typedef enum logic [2:0] {IDLE, VRD, VWR, DRAIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, cap_idx, rd_idx;
  logic [N-1:0]  base_q, base_d, beat_addr;
  logic [V-1:0]  wdata_q, wdata_d, rdata_v_q, rdata_v_d;
  logic          rvalid_q, redo_q, cap;
  logic [N-1:0]  mem_addr, mem_wdata;
  logic [3:0]    mem_byteen;
  logic          mem_rden, mem_wren, busy, done_v;
  // read data lags its strobe by one cycle; a response lost while frozen is re-fetched from beat-1
  assign cap_idx = beat_q - 1'b1;
  assign rd_idx = redo_q ? cap_idx : beat_q;
  assign beat_addr = base_q + {{(N-BW-2){1'b0}}, rd_idx, 2'b00};
  assign cap = bus.en & rvalid_q & (state_q == VRD || state_q == DRAIN);
  always_comb begin
    rdata_v_d = rdata_v_q;
    if (cap) rdata_v_d[cap_idx*N +: N] = bus.rdata_mem;
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    base_d = base_q;
    wdata_d = wdata_q;
    mem_addr = '0;
    mem_byteen = '0;
    mem_wdata = '0;
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    busy = 1'b0;
    done_v = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vec_req) begin
          busy = 1'b1;
          if (bus.en) begin
            base_d = {bus.addr[N-1:2], 2'b00};
            wdata_d = bus.wdata_v;
            beat_d = '0;
            state_d = bus.write ? VWR : VRD;
          end
        end else if (bus.scalar_req) begin
          mem_addr = bus.addr;
          mem_byteen = bus.byte_en;
          mem_wdata = bus.wdata;
          mem_wren = bus.en & bus.write;
          mem_rden = bus.en & !bus.write;
        end
      end
      VWR: begin
        busy = 1'b1;
        mem_addr = beat_addr;
        mem_byteen = 4'hF;
        mem_wdata = wdata_q[beat_q*N +: N];
        mem_wren = bus.en;
        if (bus.en) begin
          beat_d = beat_q + 1'b1;
          state_d = (beat_q == LAST) ? DONE : VWR;
        end
      end
      VRD: begin
        busy = 1'b1;
        mem_addr = beat_addr;
        mem_byteen = 4'hF;
        mem_rden = bus.en;
        if (bus.en && !redo_q) begin
          beat_d = beat_q + 1'b1;
          state_d = (beat_q == LAST) ? DRAIN : VRD;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (bus.en && redo_q) begin
          mem_addr = beat_addr;
          mem_byteen = 4'hF;
          mem_rden = 1'b1;
        end else if (bus.en) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_v = bus.en;
        state_d = bus.en ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q <= '0;
      base_q <= '0;
      wdata_q <= '0;
      rdata_v_q <= '0;
      rvalid_q <= 1'b0;
      redo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      rdata_v_q <= rdata_v_d;
      rvalid_q <= mem_rden & (state_q != IDLE);
      redo_q <= !bus.en & (redo_q | rvalid_q);
    end
  end
  assign bus.mem_addr = mem_addr;
  assign bus.mem_byteen = mem_byteen;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_rden = mem_rden;
  assign bus.mem_wren = mem_wren;
  assign bus.busy = busy;
  assign bus.done_v = done_v;
  assign bus.rdata = bus.rdata_mem;
  assign bus.rdata_v = rdata_v_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: directed scalar/vector scenarios checked cycle by cycle against an expected-trace model
module tb_vector_mem_sequencer;
  localparam int N = 32;
  localparam int V = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vector_mem_sequencer_if #(.N(N), .V(V)) bus();
  vector_mem_sequencer #(.N(N), .V(V)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic en, sc, vc, wr;
    logic [3:0] be;
    logic [31:0] a, wd;
    logic [255:0] wv;
  } stim_t;
  typedef struct {
    logic busy, done, rden, wren;
    logic [3:0] be;
    logic [31:0] a, wd;
    logic rdc;
    logic [31:0] rd;
    logic rvc;
    logic [255:0] rv;
  } exp_t;
  stim_t sq[$];
  exp_t eq[$];
  int total = 0;
  int bad = 0;
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(int'(a[31:2])) ? mem[int'(a[31:2])] : 32'h0;
  endfunction
  // byte-enabled word memory with one-cycle read latency
  always @(posedge clk) begin
    logic [31:0] w;
    if (!rst_n) bus.rdata_mem <= '0;
    else begin
      if (bus.mem_rden) bus.rdata_mem <= memrd(bus.mem_addr);
      if (bus.mem_wren) begin
        w = memrd(bus.mem_addr);
        for (int b = 0; b < 4; b++) if (bus.mem_byteen[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        mem[int'(bus.mem_addr[31:2])] = w;
      end
    end
  end
  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  function automatic stim_t si(input logic en);
    stim_t s;
    s = '{default: '0};
    s.en = en;
    return s;
  endfunction
  function automatic exp_t ei();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction
  task automatic push(input stim_t s, input exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask
  task automatic run();
    stim_t s;
    exp_t e;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      bus.en = s.en; bus.scalar_req = s.sc; bus.vec_req = s.vc; bus.write = s.wr;
      bus.byte_en = s.be; bus.addr = s.a; bus.wdata = s.wd; bus.wdata_v = s.wv;
      @(negedge clk);
      chk("busy", bus.busy, e.busy);
      chk("done_v", bus.done_v, e.done);
      chk("rden", bus.mem_rden, e.rden);
      chk("wren", bus.mem_wren, e.wren);
      if (e.rden || e.wren) begin
        chk("addr", bus.mem_addr, e.a);
        chk("byteen", bus.mem_byteen, e.be);
      end
      if (e.wren) chk("wdata", bus.mem_wdata, e.wd);
      if (e.rdc) chk("rdata", bus.rdata, e.rd);
      if (e.rvc) chk("rdata_v", bus.rdata_v, e.rv);
      chk("rdata_pass", bus.rdata, bus.rdata_mem);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(si(1'b1), ei());
  endtask
  task automatic scalar(input logic wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    stim_t s;
    exp_t e;
    s = si(1'b1); s.sc = 1'b1; s.wr = wr; s.a = a; s.be = be; s.wd = wd;
    e = ei(); e.wren = wr; e.rden = !wr; e.a = a; e.be = be; e.wd = wd;
    push(s, e);
    e = ei();
    e.rdc = !wr;
    e.rd = memrd(a);
    push(si(1'b1), e);
  endtask
  // request cycle, one cycle per beat (plus frozen cycles and a re-fetch), drain for loads, done pulse
  task automatic vop(input logic wr, input logic sc, input logic [31:0] base, input logic [255:0] wv,
                     input int gap_at, input int gap_n);
    stim_t s;
    exp_t e;
    logic [31:0] ab;
    logic [255:0] rv;
    ab = {base[31:2], 2'b00};
    rv = '0;
    s = si(1'b1); s.vc = 1'b1; s.sc = sc; s.wr = wr; s.a = base; s.wv = wv; s.be = 4'h5; s.wd = 32'h0BAD_F00D;
    e = ei(); e.busy = 1'b1;
    push(s, e);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_n; g++) begin
          e = ei(); e.busy = 1'b1;
          push(si(1'b0), e);
        end
        if (!wr && i > 0) begin
          e = ei(); e.busy = 1'b1; e.rden = 1'b1; e.be = 4'hF; e.a = ab + 32'(4 * (i - 1));
          push(si(1'b1), e);
        end
      end
      e = ei(); e.busy = 1'b1; e.wren = wr; e.rden = !wr; e.be = 4'hF;
      e.a = ab + 32'(4 * i);
      e.wd = wv[32*i +: 32];
      push(si(1'b1), e);
      rv[32*i +: 32] = memrd(ab + 32'(4 * i));
    end
    if (!wr) begin
      e = ei(); e.busy = 1'b1;
      push(si(1'b1), e);
    end
    s = si(1'b1); s.vc = 1'b1; s.wr = wr; s.a = base;
    e = ei(); e.done = 1'b1; e.rvc = !wr; e.rv = rv;
    push(s, e);
  endtask
  logic [255:0] wv, wv2;
  logic [255:0] rv_lit;
  initial begin
    bus.en = 1'b0; bus.scalar_req = 1'b0; bus.vec_req = 1'b0; bus.write = 1'b0;
    bus.byte_en = '0; bus.addr = '0; bus.wdata = '0; bus.wdata_v = '0;
    rv_lit = 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
    for (int i = 0; i < 8; i++) begin
      wv[32*i +: 32] = 32'h1111_1111 * i;
      wv2[32*i +: 32] = 32'hA5A5_0000 + i;
      mem[(32'h200 >> 2) + i] = 32'hA0 + i;
    end
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done_v, 1'b0);
    chk("rst_wren", bus.mem_wren, 1'b0);
    chk("rst_rden", bus.mem_rden, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_rdata_v", bus.rdata_v, 256'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    scalar(1'b1, 32'h10, 4'h3, 32'hDEAD_BEEF);
    run();
    chk("mem_10", memrd(32'h10), 32'h0000_BEEF);
    scalar(1'b0, 32'h10, 4'hF, 32'h0);
    run();
    chk("scalar_ld", bus.rdata, 32'h0000_BEEF);
    vop(1'b1, 1'b0, 32'h100, wv, 99, 0);
    run();
    for (int i = 0; i < 8; i++) chk("vst_mem", memrd(32'h100 + 32'(4 * i)), 32'h1111_1111 * i);
    chk("vst_mem_11c", memrd(32'h11C), 32'h7777_7777);
    vop(1'b0, 1'b0, 32'h200, '0, 99, 0);
    run();
    chk("vld_lit", bus.rdata_v, rv_lit);
    vop(1'b0, 1'b0, 32'h203, '0, 99, 0);
    run();
    chk("vld_unaligned_lit", bus.rdata_v, rv_lit);
    vop(1'b1, 1'b0, 32'hFFFF_FFF8, wv, 99, 0);
    run();
    chk("wrap_mem_0", memrd(32'h0), 32'h2222_2222);
    chk("wrap_mem_fc", memrd(32'hFFFF_FFFC), 32'h1111_1111);
    vop(1'b1, 1'b1, 32'h400, wv2, 99, 0);
    run();
    chk("both_mem_400", memrd(32'h400), 32'hA5A5_0000);
    vop(1'b1, 1'b0, 32'h500, wv, 4, 3);
    run();
    chk("gap_mem_510", memrd(32'h510), 32'h4444_4444);
    vop(1'b0, 1'b0, 32'h200, '0, 4, 3);
    run();
    chk("gap_vld_lit", bus.rdata_v, rv_lit);
    vop(1'b1, 1'b0, 32'h300, wv, 99, 0);
    while (sq.size() > 6) begin
      void'(sq.pop_back());
      void'(eq.pop_back());
    end
    run();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_wren", bus.mem_wren, 1'b0);
    chk("midrst_rdata_v", bus.rdata_v, 256'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_mem_310", memrd(32'h310), 32'h4444_4444);
    chk("midrst_mem_314", memrd(32'h314), 32'h0);
    scalar(1'b1, 32'h10, 4'h3, 32'hDEAD_BEEF);
    idle(2);
    run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
